// File: rtl/i2s_master_tx.sv
// Philips-I2S master transmitter: divides clk into BCLK/LRCLK and shifts 16-bit stereo pairs onto DACDAT.
// Define I2S_ADC_RX_EN to add a receiver that deserialises adcdat into rx_l/rx_r with the same frame timing.
module i2s_master_tx #(
   parameter int BCLK_DIV  = 16,
   parameter int SLOT_BITS = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic signed [SLOT_BITS-1:0] sample_l,
   input  logic signed [SLOT_BITS-1:0] sample_r,
   input  logic                        sample_valid,
   output logic                        sample_ready,
   output logic                        bclk,
   output logic                        lrclk,
   output logic                        dacdat,
   output logic                        underrun,
`ifdef I2S_ADC_RX_EN
   input  logic                        adcdat,
   output logic signed [SLOT_BITS-1:0] rx_l,
   output logic signed [SLOT_BITS-1:0] rx_r,
   output logic                        rx_valid,
`endif
   output logic                        busy
);

   localparam int FRAME_BITS = 2 * SLOT_BITS;
   localparam int DIV_W      = $clog2(BCLK_DIV);
   localparam int K_W        = $clog2(FRAME_BITS);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                      state, state_nxt;
   logic [DIV_W-1:0]            div_cnt;
   logic [K_W-1:0]              k, k_nxt;
   logic                        tail;
   logic [FRAME_BITS-1:0]       shreg;
   logic                        buf_full;
   logic signed [SLOT_BITS-1:0] buf_l, buf_r;
   logic                        div_tc, bclk_rise, bclk_fall, k_last;
   logic                        load, finish, xfer;

   always_comb begin
      div_tc    = (div_cnt == DIV_W'(BCLK_DIV - 1));
      // tail = DRAIN after the final falling edge: bclk is held low until IDLE
      bclk_rise = (state != IDLE) && div_tc && !bclk && !tail;
      bclk_fall = (state != IDLE) && div_tc && bclk;
      k_last    = (k == K_W'(FRAME_BITS - 1));
      k_nxt     = k_last ? '0 : k + K_W'(1);
      finish    = (state == DRAIN) && tail && div_tc;
      load      = ((state == IDLE) && en) || ((state == RUN) && bclk_fall && k_last);
      xfer      = sample_valid && sample_ready;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (en)     state_nxt = RUN;
         RUN:     if (!en)    state_nxt = DRAIN;
         DRAIN:   if (finish) state_nxt = IDLE;
         default:             state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt  <= '0;
         bclk     <= 1'b0;
         k        <= '0;
         lrclk    <= 1'b0;
         dacdat   <= 1'b0;
         tail     <= 1'b0;
         underrun <= 1'b0;
         buf_full <= 1'b0;
      end else begin
         underrun <= load && !buf_full;
         // a pair accepted during a load is kept for the following frame
         if (xfer)      buf_full <= 1'b1;
         else if (load) buf_full <= 1'b0;

         if ((state == IDLE) || finish) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
            k       <= '0;
            lrclk   <= 1'b0;
            dacdat  <= 1'b0;
            tail    <= 1'b0;
         end else begin
            div_cnt <= div_tc ? '0 : div_cnt + DIV_W'(1);
            if (bclk_rise) bclk <= 1'b1;
            if (bclk_fall) begin
               bclk   <= 1'b0;
               k      <= k_nxt;
               lrclk  <= (k_nxt >= K_W'(SLOT_BITS));
               dacdat <= shreg[FRAME_BITS-1];
               if ((state == DRAIN) && k_last) tail <= 1'b1;
            end
         end
      end
   end

   // Sample data path: no reset, qualified by the control above
   always_ff @(posedge clk) begin
      if (xfer) begin
         buf_l <= sample_l;
         buf_r <= sample_r;
      end
      if (load)           shreg <= buf_full ? {buf_l, buf_r} : '0;
      else if (bclk_fall) shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
   end

   assign sample_ready = !buf_full;
   assign busy         = (state != IDLE);

`ifdef I2S_ADC_RX_EN
   logic [FRAME_BITS-1:0] rx_sh;
   logic                  rx_armed;

   // The rise at k=0 carries the previous frame's R LSB, completing the word
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_l     <= '0;
         rx_r     <= '0;
         rx_valid <= 1'b0;
         rx_armed <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if (state == IDLE) begin
            rx_armed <= 1'b0;
         end else if (bclk_rise) begin
            if (k != '0) begin
               rx_armed <= 1'b1;
            end else if (rx_armed) begin
               {rx_l, rx_r} <= {rx_sh[FRAME_BITS-2:0], adcdat};
               rx_valid     <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (bclk_rise) rx_sh <= {rx_sh[FRAME_BITS-2:0], adcdat};
   end
`endif

endmodule

// File: tb/tb_i2s_master_tx.sv
// Scoreboard bench for i2s_master_tx (BCLK_DIV=2, SLOT_BITS=16): frame loads and clock phase are
// predicted from elapsed clk count; the monitor deserialises dacdat at bclk falling edges.
`timescale 1ns/1ps
module tb_i2s_master_tx;
   localparam int B  = 2;
   localparam int S  = 16;
   localparam int NB = 2 * S;
   localparam int F  = 2 * NB * B;   // clk cycles per frame

   logic         clk = 1'b0, rst = 1'b1, en = 1'b0, sample_valid = 1'b0;
   logic [S-1:0] sample_l = '0, sample_r = '0;
   logic         sample_ready, bclk, lrclk, dacdat, underrun, busy;
`ifdef I2S_ADC_RX_EN
   logic         adcdat;
   logic [S-1:0] rx_l, rx_r;
   logic         rx_valid;
   assign adcdat = dacdat;
`endif

   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   i2s_master_tx #(.BCLK_DIV(B), .SLOT_BITS(S)) dut (
      .clk(clk), .rst(rst), .en(en), .sample_l(sample_l), .sample_r(sample_r),
      .sample_valid(sample_valid), .sample_ready(sample_ready), .bclk(bclk),
      .lrclk(lrclk), .dacdat(dacdat), .underrun(underrun),
`ifdef I2S_ADC_RX_EN
      .adcdat(adcdat), .rx_l(rx_l), .rx_r(rx_r), .rx_valid(rx_valid),
`endif
      .busy(busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: loads happen every F clks after the start edge, a drain ends B clks
   // after the frame in progress completes, and the holding buffer is a single slot.
   logic [31:0] exp_q[$];
   logic [31:0] rx_q[$];
   logic [31:0] m_buf;
   bit          m_active, m_drain, m_full, exp_underrun;
   int          r, stop_r;

   always @(posedge clk) begin
      bit take, load_now;
      take         = sample_valid && !m_full;
      load_now     = 1'b0;
      exp_underrun = 1'b0;
      if (rst) begin
         m_active = 1'b0;
         m_drain  = 1'b0;
         m_full   = 1'b0;
         exp_q.delete();
      end else begin
         if (!m_active) begin
            if (en) begin
               m_active = 1'b1;
               m_drain  = 1'b0;
               r        = 0;
               load_now = 1'b1;
            end
         end else begin
            r++;
            if (m_drain) begin
               if (r == stop_r) m_active = 1'b0;
            end else begin
               if (r % F == 0) load_now = 1'b1;
               if (!en) begin
                  m_drain = 1'b1;
                  stop_r  = (r / F + 1) * F + B;
               end
            end
         end
         if (load_now) begin
            if (m_full) begin
               exp_q.push_back(m_buf);
               m_full = 1'b0;
            end else begin
               exp_q.push_back(32'h0);
               exp_underrun = 1'b1;
            end
         end
         if (take) begin
            m_buf  = {sample_l, sample_r};
            m_full = 1'b1;
         end
      end
   end

   // Monitor
   int          q;
   logic [31:0] acc, e;
   bit          prev_bclk;

   always @(posedge clk) begin
      #2;
      if (rst) begin
         check("reset_outputs", 32'({bclk, lrclk, dacdat, underrun, busy, sample_ready}), 32'h1);
         q = 0;
         acc = '0;
         prev_bclk = 1'b0;
         rx_q.delete();
      end else begin
         check("busy", 32'(busy), 32'(m_active));
         check("bclk", 32'(bclk), m_active ? 32'((r / B) % 2) : 32'h0);
         check("sample_ready", 32'(sample_ready), 32'(!m_full));
         check("underrun", 32'(underrun), 32'(exp_underrun));
         if (!busy) check("idle_lines", 32'({lrclk, dacdat}), 32'h0);
         if (prev_bclk && !bclk) begin
            q++;
            acc = {acc[30:0], dacdat};
            check("lrclk", 32'(lrclk), 32'((q % NB) >= S));
            if (q % NB == 0) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL frame: got %h expected no frame at %0t", acc, $time);
               end else begin
                  e = exp_q.pop_front();
                  check("frame", acc, e);
`ifdef I2S_ADC_RX_EN
                  check("rx_missing", 32'(rx_q.size()), 32'h0);
`endif
                  rx_q.push_back(e);
               end
            end
         end
         prev_bclk = bclk;
`ifdef I2S_ADC_RX_EN
         if (rx_valid) begin
            if (rx_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL rx: got %h expected no rx_valid at %0t", {rx_l, rx_r}, $time);
            end else begin
               check("rx", {rx_l, rx_r}, rx_q.pop_front());
            end
         end
`endif
         if (!busy) begin
            q = 0;
            rx_q.delete();
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input logic [31:0] v);
      int guard = 0;
      {sample_l, sample_r} = v;
      sample_valid = 1'b1;
      while (!sample_ready && guard < 4 * F) begin
         @(negedge clk);
         guard++;
      end
      check("push_ready", 32'(sample_ready), 32'h1);
      @(negedge clk);
      sample_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int guard = 0;
      while (busy && guard < 3 * F) begin
         @(negedge clk);
         guard++;
      end
      check("drain_to_idle", 32'(busy), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      bit took;
      int len;
      step(3);
      check("reset_ready", 32'(sample_ready), 32'h1);
      check("reset_busy", 32'(busy), 32'h0);
      rst = 1'b0;
      step(2);

      // Directed frames, then one underrun frame, then drain
      push(32'hA5A5_0F0F);
      en = 1'b1;
      push(32'h8001_7FFE);
      step(2 * F + 20);
      en = 1'b0;
      wait_idle();
      step(3);

      // Running with nothing pushed; stop inside the left slot
      en = 1'b1;
      step(3 * F + 30);
      en = 1'b0;
      wait_idle();
      step(2);

      // Back-to-back stream with valid held high
      {sample_l, sample_r} = $urandom;
      sample_valid = 1'b1;
      en = 1'b1;
      for (int c = 0; c < 8 * F; c++) begin
         took = sample_valid && sample_ready;
         @(negedge clk);
         if (took) {sample_l, sample_r} = $urandom;
      end
      sample_valid = 1'b0;
      en = 1'b0;
      wait_idle();
      step(2);

      // Random bursts with sparse valid; en blips during drain
      for (int b = 0; b < 4; b++) begin
         en = 1'b1;
         len = $urandom_range(F / 2, 3 * F);
         for (int c = 0; c < len; c++) begin
            took = sample_valid && sample_ready;
            @(negedge clk);
            if (took || !sample_valid) begin
               sample_valid = ($urandom_range(0, 3) == 0);
               {sample_l, sample_r} = $urandom;
            end
         end
         en = 1'b0;
         step(10);
         en = 1'b1;
         step(5);
         en = 1'b0;
         wait_idle();
         step($urandom_range(1, 4));
      end
      sample_valid = 1'b0;
      step(2);

      // Asynchronous reset at k=20 of the second frame, then a clean restart
      en = 1'b1;
      step(F + 82);
      rst = 1'b1;
      #1;
      check("async_reset", 32'({bclk, lrclk, dacdat, underrun, busy, sample_ready}), 32'h1);
      step(1);
      rst = 1'b0;
      en = 1'b0;
      step(3);
      en = 1'b1;
      push($urandom);
      step(2 * F);
      en = 1'b0;
      wait_idle();

      step(5);
      check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/i2s_master_tx.md
Name: i2s_master_tx

Overview:
- I2S bus master and transmitter for a WM8731-class codec running in slave mode.
- Divides the system clock to generate BCLK and LRCLK, and serialises 16-bit stereo sample pairs onto DACDAT in Philips I2S format.
- Provides the clock-generating, sending end of the interface that the audio loop currently consumes as a receiver; codec clocks become outputs.
- Upstream logic (adaptive filter, Ethernet audio path) feeds it through a one-entry valid/ready buffer.

Parameters:
- BCLK_DIV, 16: clk cycles per BCLK half-period; must be ≥2. At 50 MHz this gives BCLK = 1.5625 MHz.
- SLOT_BITS, 16: BCLK cycles per channel slot and sample width. Frame = 2*SLOT_BITS BCLKs, fs ≈ 48.8 kHz.

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  asynchronous active-high reset
- en  in  1  run request
- sample_l  in  SLOT_BITS  left sample, two's complement
- sample_r  in  SLOT_BITS  right sample
- sample_valid  in  1  sample pair valid
- sample_ready  out  1  holding buffer empty
- bclk  out  1  bit clock to codec
- lrclk  out  1  DACLRC to codec; 0 = left, 1 = right
- dacdat  out  1  serial data, changes on bclk falling edge
- underrun  out  1  one-clk pulse, frame started with empty buffer
- busy  out  1  high when not IDLE

Behaviour:
- Reset, async: all outputs 0 except sample_ready = 1; holding buffer empty; state IDLE. Reset mid-frame aborts immediately with no completion.
- Handshake: transfer occurs when sample_valid && sample_ready. The pair is captured into the holding buffer and sample_ready drops the next clk. sample_ready rises the clk after a frame load empties the buffer. The buffer accepts data in any state, including IDLE.
- Divider: div_cnt counts 0..BCLK_DIV-1 in RUN/DRAIN. At the terminal count, bclk toggles and div_cnt wraps. Every bclk edge is a registered output; there is no gated clock.
- Bit counter k runs 0..2*SLOT_BITS-1 and advances on each bclk falling edge. lrclk = (k ≥ SLOT_BITS) and updates on the falling edge with k.
- Frame load at every k=0 falling edge, and on IDLE→RUN entry:
  - Buffer full: shift register ← {sample_l, sample_r}, buffer empties.
  - Buffer empty: shift register ← 0, underrun pulses for 1 clk.
  - A transfer completing in the same clk as a load goes to the buffer for the next frame and is not lost.
- Data: dacdat equals the shift-register MSB delayed one BCLK, which is the I2S one-bit delay. The MSB of L appears during k=1. The LSB of R appears during k=0 of the next frame, or of the DRAIN tail.
- FSM states:
  - IDLE: bclk=0, lrclk=0, dacdat=0. en=1 → RUN; the first frame loads in the transition clk, bclk stays low for BCLK_DIV clks, then rises.
  - RUN: en=0 seen at any point → DRAIN. The current frame continues.
  - DRAIN: completes k=2*SLOT_BITS-1, then outputs one final falling-edge bit (R LSB, lrclk=0), then holds bclk low for BCLK_DIV clks → IDLE. No new load occurs. If en re-asserts during DRAIN, it is honoured only after IDLE is reached.
- Latency: accepted sample to its MSB on dacdat is ≤ one frame plus 1 BCLK.

Optional Feature:
- Macro I2S_ADC_RX_EN.
- When defined:
  - Adds input adcdat (1 bit) and outputs rx_l, rx_r (SLOT_BITS each) and rx_valid (1 bit).
  - adcdat is sampled on the clk in which bclk rises, using the same one-bit I2S delay.
  - After the last R bit (the rise at k=0 of the next frame), rx_l/rx_r update and rx_valid pulses 1 clk.
  - rx_* reset to 0. No capture occurs in IDLE.
- When undefined: those ports are absent and there is no receive logic.

Test Plan:
- BCLK_DIV=2, SLOT_BITS=16, push L=16'hA5A5, R=16'h0F0F, raise en → bclk period 4 clk, frame 128 clk; dacdat bits k=1..16 = A5A5 MSB-first, k=17..32 = 0F0F (k=32 is next frame's k=0); lrclk low for k=0..15.
- en high, no sample pushed → underrun one-clk pulse at each frame load; dacdat constant 0; busy=1.
- sample_valid held high with stream 1,2,3… → exactly one pair accepted per frame; sample_ready low except the clk after each load; no value skipped or duplicated over 8 frames.
- Drop en mid-left-slot → frame completes, R LSB emitted, bclk low, busy=0 after BCLK_DIV clks; no further load or underrun.
- Assert rst for 1 clk at k=20 → all outputs 0 asynchronously and sample_ready=1; restart cleanly from k=0 on en.
- With I2S_ADC_RX_EN defined, loop dacdat to adcdat with L=16'h8001, R=16'h7FFE → rx_l=8001, rx_r=7FFE, rx_valid one pulse per frame.
